// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode values, operand-length decode and fetch
// sequencer state encodings.
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDO  = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_STO  = 4'h3;
    localparam logic [3:0] OP_PRE  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_LDM  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_CLR  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ST_FETCH_OP  = 3'd0;
    localparam logic [2:0] ST_FETCH_ARG = 3'd1;
    localparam logic [2:0] ST_DATA_RD   = 3'd2;
    localparam logic [2:0] ST_ISSUE     = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    // Ops whose second byte is an address operand.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Fetch/operand sequencer owning the program ROM port; assembles one
// instruction per handshake, resolves JMP internally and parks on HLT.
module rom_fetch_ctrl
    import cpu_isa_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read,
    output logic              rom_ena,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [3:0]        ins_op,
    output logic [3:0]        ins_reg,
    output logic [7:0]        ins_arg,
    output logic [7:0]        ins_rdata,
    input  logic              resume,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        arg_q, arg_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        rom_byte;

    assign rom_byte = rom_data[7:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        arg_d    = arg_q;
        rdata_d  = rdata_q;
        rom_addr = pc_q;
        rom_read = 1'b0;
        case (state_q)
            ST_FETCH_OP: begin
                rom_read = 1'b1;
                ir_d     = rom_byte;
                pc_d     = pc_q + ADDR_W'(1);
                arg_d    = '0;
                rdata_d  = '0;
                state_d  = is_two_byte(rom_byte[7:4]) ? ST_FETCH_ARG : ST_ISSUE;
            end
            ST_FETCH_ARG: begin
                rom_read = 1'b1;
                arg_d    = rom_byte;
                pc_d     = pc_q + ADDR_W'(1);
                if (ir_q[7:4] == OP_LDO) begin
                    state_d = ST_DATA_RD;
                end else if (ir_q[7:4] == OP_JMP) begin
                    // JMP is consumed here and never reaches the execute stage.
                    pc_d    = ADDR_W'(rom_byte);
                    state_d = ST_FETCH_OP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DATA_RD: begin
                rom_addr = ADDR_W'(arg_q);
                rom_read = 1'b1;
                rdata_d  = rom_byte;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ins_ready) begin
                    state_d = (ir_q[7:4] == OP_HLT) ? ST_HALT : ST_FETCH_OP;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH_OP;
                end
            end
            default: state_d = ST_FETCH_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH_OP;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            arg_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            arg_q   <= arg_d;
            rdata_q <= rdata_d;
        end
    end

    assign rom_ena   = rom_read;
    assign ins_valid = (state_q == ST_ISSUE);
    assign halted    = (state_q == ST_HALT);
    assign pc        = pc_q;
    assign ins_op    = ir_q[7:4];
    assign ins_reg   = ir_q[3:0];
    assign ins_arg   = arg_q;
    assign ins_rdata = rdata_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: ROM models, issue scoreboard,
// table-driven instruction stream and hand-written corner sequences.
module tb_rom_fetch_ctrl;

    logic       clk;
    logic       rst, ins_ready, resume;
    logic [7:0] rom_data, rom_addr, pc;
    logic       rom_read, rom_ena, ins_valid, halted;
    logic [3:0] ins_op, ins_reg;
    logic [7:0] ins_arg, ins_rdata;

    logic       rst_w, ready_w;
    logic [7:0] w_rom_data, w_rom_addr, w_pc;
    logic       w_rom_read, w_rom_ena, w_valid, w_halted;
    logic [3:0] w_op, w_reg;
    logic [7:0] w_arg, w_rdata;

    logic [7:0] rom  [256];
    logic [7:0] rom2 [256];

    assign rom_data   = rom[rom_addr];
    assign w_rom_data = rom2[w_rom_addr];

    rom_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .rom_data(rom_data), .rom_addr(rom_addr),
        .rom_read(rom_read), .rom_ena(rom_ena), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_op(ins_op), .ins_reg(ins_reg),
        .ins_arg(ins_arg), .ins_rdata(ins_rdata), .resume(resume),
        .halted(halted), .pc(pc)
    );

    rom_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFF)) dutw (
        .clk(clk), .rst(rst_w), .rom_data(w_rom_data), .rom_addr(w_rom_addr),
        .rom_read(w_rom_read), .rom_ena(w_rom_ena), .ins_valid(w_valid),
        .ins_ready(ready_w), .ins_op(w_op), .ins_reg(w_reg),
        .ins_arg(w_arg), .ins_rdata(w_rdata), .resume(1'b0),
        .halted(w_halted), .pc(w_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted instruction is compared with the next expected one.
    always @(negedge clk) begin
        logic [23:0] e;
        if (ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_issue: got %0h expected none",
                         {ins_op, ins_reg, ins_arg, ins_rdata});
            end else begin
                e = exp_q.pop_front();
                check("issue", {ins_op, ins_reg, ins_arg, ins_rdata}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ins_valid && n < 10);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int unsigned nb;
        logic [23:0] exp;
        int unsigned lat;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        int addr;
        logic seen;

        tbl[0]  = '{8'h45, 8'h00, 1, 24'h450000, 1};
        tbl[1]  = '{8'h57, 8'h00, 1, 24'h570000, 1};
        tbl[2]  = '{8'h6A, 8'h00, 1, 24'h6A0000, 1};
        tbl[3]  = '{8'h7F, 8'h00, 1, 24'h7F0000, 1};
        tbl[4]  = '{8'h81, 8'h00, 1, 24'h810000, 1};
        tbl[5]  = '{8'h92, 8'h00, 1, 24'h920000, 1};
        tbl[6]  = '{8'hC3, 8'h00, 1, 24'hC30000, 1};
        tbl[7]  = '{8'hD4, 8'h00, 1, 24'hD40000, 1};
        tbl[8]  = '{8'hE5, 8'h00, 1, 24'hE50000, 1};
        tbl[9]  = '{8'h25, 8'h40, 2, 24'h254000, 2};
        tbl[10] = '{8'h3A, 8'h41, 2, 24'h3A4100, 2};
        tbl[11] = '{8'h1C, 8'h60, 2, 24'h1C605A, 3};
        tbl[12] = '{8'h00, 8'h00, 1, 24'h000000, 1};

        rst = 1'b1; ins_ready = 1'b1; resume = 1'b0;
        rst_w = 1'b1; ready_w = 1'b1;
        for (int i = 0; i < 256; i++) rom2[i] = 8'h00;

        // Reset, NOP, then LDO with data read
        clear_rom();
        rom[1] = 8'h11; rom[2] = 8'h81; rom[129] = 8'h64;
        step(); step();
        check("reset_state", {ins_valid, halted, pc, ins_op, ins_reg, ins_arg, ins_rdata}, 34'h0);
        check("reset_rom_port", {rom_addr, rom_read, rom_ena}, {8'h00, 1'b1, 1'b1});
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h118164);
        rst = 1'b0;
        wait_valid(n);
        check("nop_latency", n, 1);
        step();
        check("ldo_fetch_addr", {ins_valid, rom_addr}, {1'b0, 8'h01});
        wait_valid(n);
        check("ldo_latency", n, 3);
        check("ldo_pc", pc, 8'h03);
        rst = 1'b1; step();

        // Chained JMPs: 0 -> 9 -> 15, then CLR
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'h09; rom[9] = 8'hA3; rom[10] = 8'h0F; rom[15] = 8'hB0;
        step();
        exp_q.push_back(24'hB00000);
        rst = 1'b0; seen = 1'b0;
        step(); seen |= ins_valid;
        step(); seen |= ins_valid;
        check("jmp1_target", rom_addr, 8'h09);
        step(); seen |= ins_valid;
        step(); seen |= ins_valid;
        check("jmp2_target", {rom_addr, rom_read}, {8'h0F, 1'b1});
        check("jmp_not_issued", seen, 1'b0);
        step();
        check("clr_valid", ins_valid, 1'b1);
        rst = 1'b1; step();

        // Back-pressure on STO; resume outside HALT must do nothing
        clear_rom();
        rom[0] = 8'h34; rom[1] = 8'h02;
        ins_ready = 1'b0;
        step();
        rst = 1'b0;
        wait_valid(n);
        check("sto_latency", n, 2);
        resume = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {ins_valid, ins_op, ins_reg, ins_arg, ins_rdata}, {1'b1, 24'h340200});
            check("bp_rom_idle", {rom_read, rom_ena, pc}, {1'b0, 1'b0, 8'h02});
            step();
        end
        resume = 1'b0;
        exp_q.push_back(24'h340200);
        ins_ready = 1'b1;
        step();
        check("bp_release", {ins_valid, halted, rom_addr}, {1'b0, 1'b0, 8'h02});
        rst = 1'b1; step();

        // HLT, stay halted with ins_ready high, resume
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'h0E; rom[14] = 8'hF0; rom[15] = 8'hB0;
        step();
        exp_q.push_back(24'hF00000);
        rst = 1'b0;
        wait_valid(n);
        check("hlt_latency", n, 3);
        step();
        check("halt_enter", {halted, ins_valid, rom_read, pc}, {1'b1, 1'b0, 1'b0, 8'h0F});
        step(); step();
        check("halt_stays", {halted, pc}, {1'b1, 8'h0F});
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_fetch", {halted, rom_addr, rom_read}, {1'b0, 8'h0F, 1'b1});
        exp_q.push_back(24'hB00000);
        wait_valid(n);
        check("post_resume_latency", n, 1);
        rst = 1'b1; step();

        // Table-driven instruction stream
        clear_rom();
        addr = 0;
        foreach (tbl[i]) begin
            rom[addr] = tbl[i].b0;
            if (tbl[i].nb == 2) rom[addr + 1] = tbl[i].b1;
            addr += int'(tbl[i].nb);
            exp_q.push_back(tbl[i].exp);
        end
        rom[8'h60] = 8'h5A;
        step();
        rst = 1'b0;
        foreach (tbl[i]) begin
            wait_valid(n);
            check($sformatf("tbl_latency_%0d", i), n, tbl[i].lat + ((i == 0) ? 0 : 1));
        end
        rst = 1'b1; step();

        // Reset in the middle of DATA_RD drops the LDO
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h81;
        step();
        rst = 1'b0;
        step(); step();
        check("mid_ldo_data_addr", rom_addr, 8'h81);
        rst = 1'b1;
        step();
        check("rst_mid_ldo", {ins_valid, pc, rom_addr, halted, rom_read}, {1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); seen |= ins_valid;
        end
        check("rst_no_issue", seen, 1'b0);

        // PC wrap with RESET_PC = FF: two-byte op takes its argument from 00
        rom2[8'hFF] = 8'h32; rom2[8'h00] = 8'h07;
        step();
        check("wrap_reset_pc", {w_pc, w_rom_addr}, {8'hFF, 8'hFF});
        rst_w = 1'b0;
        step();
        check("wrap_arg_addr", {w_rom_addr, w_pc}, {8'h00, 8'h00});
        step();
        check("wrap_issue", {w_valid, w_op, w_reg, w_arg, w_rdata, w_pc}, {1'b1, 24'h320700, 8'h01});
        rst_w = 1'b1;
        step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
